// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline computing an N-input bitwise gate across operand channels.
// Optional even-parity output enabled by defining LGP_PARITY_EN.
module logic_gate_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_err,
`ifdef LGP_PARITY_EN
    output logic                    out_parity,
`endif
    output logic [15:0]             beat_count
);

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_XOR  = 3'd2,
        GATE_NAND = 3'd3,
        GATE_NOR  = 3'd4,
        GATE_XNOR = 3'd5,
        GATE_BAD6 = 3'd6,
        GATE_BAD7 = 3'd7
    } gate_e;

    logic                    s1_valid;
    logic [NUM_IN*WIDTH-1:0] s1_data;
    gate_e                   s1_mode;

    logic       in_fire;
    logic       out_fire;
    logic       s2_load;
    logic       s1_adv;
    logic       s1_load;

    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] res;
    logic             res_err;

    // S2 accepts when empty or draining; S1 applies the same rule against S2,
    // so in_ready chains combinationally from out_ready with no bubble.
    assign out_fire = out_valid && out_ready;
    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            and_r = and_r & s1_data[k*WIDTH +: WIDTH];
            or_r  = or_r  | s1_data[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ s1_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (s1_mode)
            GATE_AND:  res = and_r;
            GATE_OR:   res = or_r;
            GATE_XOR:  res = xor_r;
            GATE_NAND: res = ~and_r;
            GATE_NOR:  res = ~or_r;
            GATE_XNOR: res = ~xor_r;
            default:   res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= GATE_AND;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_fire) begin
                s1_data <= in_data;
                s1_mode <= gate_e'(in_mode);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_adv) begin
                out_data <= res;
                out_err  <= res_err;
            end
        end
    end

`ifdef LGP_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (s1_adv) begin
            out_parity <= ^res;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (out_fire && (beat_count != '1)) begin
            beat_count <= beat_count + 16'd1;
        end
    end

endmodule
